decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 The block SHALL have a single clock `clk` and an asynchronous, active-high reset `reset`.
REQ-002 Port `clk`, input, 1 bit: clock; all register-file writes occur on its rising edge.
REQ-003 Port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port `instruction`, input, `INSTR_LEN` (32) bits: the instruction word produced by Fetch.
REQ-005 Port `write_en`, input, 1 bit: write-back enable.
REQ-006 Port `write_reg`, input, 5 bits: write-back destination register.
REQ-007 Port `write_data`, input, `WORD` (64) bits: write-back data.
REQ-008 Ports `read_data1` and `read_data2`, output, `WORD` bits each: register operands.
REQ-009 Port `imm`, output, `WORD` bits: extended immediate.
REQ-010 Port `ctrl`, output, packed struct `ctrl_t` with fields `reg2_loc`, `alu_src`, `mem_to_reg`, `reg_write`, `mem_read`, `mem_write`, `branch`, `uncond_branch`, `alu_op[1:0]`.
REQ-011 Port `illegal`, output, 1 bit: asserted when the opcode is unrecognised.

Function
REQ-012 Register file SHALL be 32 x `WORD`; X31 (XZR) SHALL always read 0, and writes to it SHALL be discarded.
REQ-013 Writes SHALL take effect on posedge `clk` when `write_en`=1; reads SHALL be combinational.
REQ-014 Read-during-write bypass: if `write_en`=1 and `write_reg` equals a read address other than 31, that read port SHALL return `write_data` in the same cycle.
REQ-015 Read address 1 SHALL be Rn = instruction[9:5].
REQ-016 Read address 2 SHALL be instruction[4:0] (Rt) when `reg2_loc`=1, else instruction[20:16] (Rm).
REQ-017 Decode table: R-type ADD/SUB/AND/ORR (11-bit opcode 0x458/0x658/0x450/0x550) -> `reg_write`=1, `alu_op`=10.
REQ-018 Decode table: ADDI/SUBI (10-bit 0x244/0x344) -> `alu_src`=1, `reg_write`=1, `alu_op`=10.
REQ-019 Decode table: LDUR (0x7C2) -> `alu_src`=1, `mem_to_reg`=1, `reg_write`=1, `mem_read`=1, `alu_op`=00.
REQ-020 Decode table: STUR (0x7C0) -> `reg2_loc`=1, `alu_src`=1, `mem_write`=1, `alu_op`=00.
REQ-021 Decode table: CBZ/CBNZ (8-bit 0xB4/0xB5) -> `reg2_loc`=1, `branch`=1, `alu_op`=01.
REQ-022 Decode table: B (6-bit 0x05) -> `uncond_branch`=1.
REQ-023 Match priority SHALL be 11-bit, then 10-bit, then 8-bit, then 6-bit opcode.
REQ-024 Unmatched opcode -> all `ctrl` fields 0 and `illegal`=1; the register file SHALL remain unaffected.
REQ-025 `imm` for I-type SHALL be instruction[21:10] zero-extended.
REQ-026 `imm` for D-type SHALL be instruction[20:12] sign-extended.
REQ-027 `imm` for CB SHALL be instruction[23:5] sign-extended and shifted left by 2.
REQ-028 `imm` for B SHALL be instruction[25:0] sign-extended and shifted left by 2.
REQ-029 `imm` for R-type or illegal instructions SHALL be 0.
REQ-030 Decode outputs SHALL have zero latency (combinational from `instruction`).

Reset
REQ-031 Asserting `reset` SHALL clear all registers to 0 immediately, independent of `clk`.
REQ-032 While `reset` is held, writes SHALL be ignored and both read ports SHALL return 0.
REQ-033 Reset asserted mid-write SHALL win; the write SHALL be lost.
REQ-034 The first write after deassertion SHALL occur at the next posedge `clk`.

Structure
REQ-035 `WORD`, `INSTR_LEN`, the opcode constants and `ctrl_t` SHALL reside in the shared constants package/header.
REQ-036 The register file SHALL be a sub-module `RegFile` (clk, reset, 2 read ports, 1 write port, bypass); decode logic SHALL remain in `decode`.

Verification
REQ-037 Reset, then write X2=5 and X3=7, apply 0x8B030041 (ADD X1,X2,X3) -> `read_data1`=5, `read_data2`=7, `reg_write`=1, `alu_op`=10, `imm`=0.
REQ-038 Apply 0xF85F8045 (LDUR X5,[X2,#-8]) -> `imm`=0xFFFFFFFFFFFFFFF8, `mem_read`=1, `mem_to_reg`=1, `alu_src`=1.
REQ-039 Apply 0xB4FFFFA7 (CBZ X7,#-3) -> `imm`=0xFFFFFFFFFFFFFFF4, `branch`=1, `reg2_loc`=1, read address 2 = 7.
REQ-040 `write_en`=1, `write_reg`=4, `write_data`=0xDEAD, reading X4 -> 0xDEAD in the same cycle; `write_reg`=31 -> XZR still reads 0 after the edge.
REQ-041 Pulse `reset` between clock edges after writes -> X1..X30 all read 0 before the next edge.
REQ-042 Apply 0x00000000 -> `illegal`=1, all `ctrl` fields 0, `imm`=0.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared widths, opcode constants and control struct for decode
package decode_pkg;
  localparam int WORD = 64;
  localparam int INSTR_LEN = 32;
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [9:0]  OP_ADDI = 10'h244;
  localparam logic [9:0]  OP_SUBI = 10'h344;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [7:0]  OP_CBNZ = 8'hB5;
  localparam logic [5:0]  OP_B    = 6'h05;
  typedef struct packed {
    logic       reg2_loc;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       uncond_branch;
    logic [1:0] alu_op;
  } ctrl_t;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_LD, FMT_ST, FMT_CB, FMT_B, FMT_ILL} fmt_e;
endpackage

// File: rtl/RegFile.sv
// RegFile: 32 x WORD register file, XZR at index 31, write-through bypass
module RegFile
  import decode_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rd_addr1,
  input  logic [4:0]      rd_addr2,
  output logic [WORD-1:0] rd_data1,
  output logic [WORD-1:0] rd_data2,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [WORD-1:0] wr_data
);
  logic [WORD-1:0] regs_q [32];
  logic [WORD-1:0] regs_d [32];
  always_comb begin
    for (int i = 0; i < 32; i++)
      regs_d[i] = (wr_en && wr_addr == 5'(i) && i != 31) ? wr_data : regs_q[i];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    else
      regs_q <= regs_d;
  end
  // bypass is suppressed under reset so both ports read 0 while it is held
  assign rd_data1 = (reset || rd_addr1 == 5'd31) ? '0 :
                    (wr_en && wr_addr == rd_addr1) ? wr_data : regs_q[rd_addr1];
  assign rd_data2 = (reset || rd_addr2 == 5'd31) ? '0 :
                    (wr_en && wr_addr == rd_addr2) ? wr_data : regs_q[rd_addr2];
endmodule

// File: rtl/decode.sv
// decode: instruction decode, immediate extension and register operand read
module decode
  import decode_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INSTR_LEN-1:0] instruction,
  input  logic                 write_en,
  input  logic [4:0]           write_reg,
  input  logic [WORD-1:0]      write_data,
  output logic [WORD-1:0]      read_data1,
  output logic [WORD-1:0]      read_data2,
  output logic [WORD-1:0]      imm,
  output ctrl_t                ctrl,
  output logic                 illegal
);
  logic [10:0] op11;
  logic [9:0]  op10;
  logic [7:0]  op8;
  logic [5:0]  op6;
  logic [4:0]  rd_addr2;
  fmt_e        fmt;
  assign op11 = instruction[31:21];
  assign op10 = instruction[31:22];
  assign op8  = instruction[31:24];
  assign op6  = instruction[31:26];
  // wider opcodes are tested first so they take priority
  assign fmt = (op11 inside {OP_ADD, OP_SUB, OP_AND, OP_ORR}) ? FMT_R :
               (op11 == OP_LDUR)                              ? FMT_LD :
               (op11 == OP_STUR)                              ? FMT_ST :
               (op10 inside {OP_ADDI, OP_SUBI})               ? FMT_I :
               (op8 inside {OP_CBZ, OP_CBNZ})                 ? FMT_CB :
               (op6 == OP_B)                                  ? FMT_B : FMT_ILL;
  always_comb begin
    ctrl = '0;
    imm = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op = 2'b10;
      end
      FMT_I: begin
        ctrl.alu_src = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op = 2'b10;
        imm = {52'b0, instruction[21:10]};
      end
      FMT_LD: begin
        ctrl.alu_src = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.mem_read = 1'b1;
        imm = {{55{instruction[20]}}, instruction[20:12]};
      end
      FMT_ST: begin
        ctrl.reg2_loc = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.mem_write = 1'b1;
        imm = {{55{instruction[20]}}, instruction[20:12]};
      end
      FMT_CB: begin
        ctrl.reg2_loc = 1'b1;
        ctrl.branch = 1'b1;
        ctrl.alu_op = 2'b01;
        imm = {{43{instruction[23]}}, instruction[23:5], 2'b00};
      end
      FMT_B: begin
        ctrl.uncond_branch = 1'b1;
        imm = {{36{instruction[25]}}, instruction[25:0], 2'b00};
      end
      default: illegal = 1'b1;
    endcase
  end
  assign rd_addr2 = ctrl.reg2_loc ? instruction[4:0] : instruction[20:16];
  RegFile u_rf (
    .clk      (clk),
    .reset    (reset),
    .rd_addr1 (instruction[9:5]),
    .rd_addr2 (rd_addr2),
    .rd_data1 (read_data1),
    .rd_data2 (read_data2),
    .wr_en    (write_en),
    .wr_addr  (write_reg),
    .wr_data  (write_data)
  );
endmodule

// File: tb/tb_decode.sv
// tb_decode: randomized scoreboard bench for decode against a behavioural model
module tb_decode;
  import decode_pkg::*;
  logic        clk = 0;
  logic        reset = 1;
  logic [31:0] instruction = '0;
  logic        write_en = 0;
  logic [4:0]  write_reg = '0;
  logic [63:0] write_data = '0;
  logic [63:0] read_data1, read_data2, imm;
  ctrl_t       ctrl;
  logic        illegal;

  decode dut (
    .clk(clk), .reset(reset), .instruction(instruction), .write_en(write_en),
    .write_reg(write_reg), .write_data(write_data), .read_data1(read_data1),
    .read_data2(read_data2), .imm(imm), .ctrl(ctrl), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm;
    ctrl_t       c;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  logic [63:0] mem [32];
  int          total = 0;
  int          bad = 0;

  function automatic void chk(input string n, input logic [63:0] a, input logic [63:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, x, $time);
    end
  endfunction

  // decode rules from the instruction table, using integer field extraction
  function automatic void model(input logic [31:0] ins, output ctrl_t c, output logic ill,
                                output logic [63:0] im);
    int unsigned u = ins;
    int unsigned o11 = u >> 21;
    int unsigned o10 = u >> 22;
    int unsigned o8 = u >> 24;
    int unsigned o6 = u >> 26;
    longint v;
    c = '0;
    ill = 0;
    im = 0;
    if (o11 == 'h458 || o11 == 'h658 || o11 == 'h450 || o11 == 'h550) begin
      c.reg_write = 1; c.alu_op = 2;
    end else if (o11 == 'h7C2 || o11 == 'h7C0) begin
      if (o11 == 'h7C2) begin
        c.mem_to_reg = 1; c.reg_write = 1; c.mem_read = 1;
      end else begin
        c.reg2_loc = 1; c.mem_write = 1;
      end
      c.alu_src = 1;
      v = longint'((u >> 12) & 'h1FF);
      if (v >= 256) v -= 512;
      im = v;
    end else if (o10 == 'h244 || o10 == 'h344) begin
      c.alu_src = 1; c.reg_write = 1; c.alu_op = 2;
      im = longint'((u >> 10) & 'hFFF);
    end else if (o8 == 'hB4 || o8 == 'hB5) begin
      c.reg2_loc = 1; c.branch = 1; c.alu_op = 1;
      v = longint'((u >> 5) & 'h7FFFF);
      if (v >= 'h40000) v -= 'h80000;
      im = v * 4;
    end else if (o6 == 5) begin
      c.uncond_branch = 1;
      v = longint'(u & 'h3FFFFFF);
      if (v >= 'h2000000) v -= 'h4000000;
      im = v * 4;
    end else ill = 1;
  endfunction

  function automatic logic [63:0] rd(input logic [4:0] a);
    if (reset || a == 31) return 64'd0;
    if (write_en && write_reg == a) return write_data;
    return mem[a];
  endfunction

  task automatic step(input logic [31:0] ins, input logic we, input logic [4:0] wr,
                      input logic [63:0] wd, input bit hold, input bit pulse);
    exp_t e;
    @(posedge clk);
    #1;
    instruction = ins;
    write_en = we;
    write_reg = wr;
    write_data = wd;
    reset = hold | pulse;
    if (reset) for (int i = 0; i < 32; i++) mem[i] = 0;
    if (pulse) begin
      #2;
      reset = 0;
    end
    model(ins, e.c, e.ill, e.imm);
    e.rd1 = rd(ins[9:5]);
    e.rd2 = rd(e.c.reg2_loc ? ins[4:0] : ins[20:16]);
    q.push_back(e);
    if (!reset && we && wr != 31) mem[wr] = wd;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rm, input logic [4:0] rn);
    return {11'h458, rm, 6'd0, rn, 5'd0};
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("read_data1", read_data1, e.rd1);
        chk("read_data2", read_data2, e.rd2);
        chk("imm", imm, e.imm);
        chk("ctrl", 64'(ctrl), 64'(e.c));
        chk("illegal", 64'(illegal), 64'(e.ill));
      end
    end
  end

  initial begin : driver
    logic [31:0] ins;
    for (int i = 0; i < 32; i++) mem[i] = 0;
    step(32'h0, 1, 5'd6, 64'h55, 1, 0);
    step(32'h8B030041, 1, 5'd2, 64'd5, 0, 0);
    step(32'h8B030041, 1, 5'd3, 64'd7, 0, 0);
    step(32'h8B030041, 0, 5'd0, 64'd0, 0, 0);
    step(32'hF85F8045, 0, 5'd0, 64'd0, 0, 0);
    step(32'hB4FFFFA7, 0, 5'd0, 64'd0, 0, 0);
    step(rtype(5'd4, 5'd4), 1, 5'd4, 64'hDEAD, 0, 0);
    step(rtype(5'd31, 5'd31), 1, 5'd31, 64'h1234, 0, 0);
    step(rtype(5'd31, 5'd31), 0, 5'd0, 64'd0, 0, 0);
    step(32'h0, 0, 5'd0, 64'd0, 0, 0);
    for (int i = 1; i <= 30; i++)
      step($urandom, 1, 5'(i), {$urandom, $urandom} | 64'd1, 0, 0);
    step(rtype(5'd1, 5'd5), 0, 5'd0, 64'd0, 0, 1);
    for (int i = 1; i < 30; i += 2)
      step(rtype(5'(i + 1), 5'(i)), 0, 5'd0, 64'd0, 0, 0);
    step(rtype(5'd4, 5'd4), 1, 5'd4, 64'd99, 1, 0);
    step(rtype(5'd4, 5'd4), 0, 5'd0, 64'd0, 0, 0);
    step(rtype(5'd4, 5'd4), 1, 5'd4, 64'd77, 0, 0);
    step(rtype(5'd4, 5'd4), 0, 5'd0, 64'd0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      case ($urandom_range(0, 11))
        0: ins[31:21] = 11'h458;
        1: ins[31:21] = 11'h658;
        2: ins[31:21] = 11'h450;
        3: ins[31:21] = 11'h550;
        4: ins[31:21] = 11'h7C2;
        5: ins[31:21] = 11'h7C0;
        6: ins[31:22] = 10'h244;
        7: ins[31:22] = 10'h344;
        8: ins[31:24] = 8'hB4;
        9: ins[31:24] = 8'hB5;
        10: ins[31:26] = 6'h05;
        default: ;
      endcase
      step(ins, 1'($urandom), 5'($urandom), {$urandom, $urandom}, 0, ($urandom_range(0, 40) == 0));
    end
    repeat (3) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
